// File: rtl/qam_demodulator.sv
// -----------------------------------------------------------------------------
// qam_demodulator
//
// 4-QAM receive correlator. Each qualified sample is multiplied by the cos and
// sin references. The products are accumulated into I and Q over one symbol of
// SAMPLES_PER_SYMBOL qualified samples. The 2-bit symbol is then decided from
// the signs of the final sums.
//
// Optional feature macro: QAM_DEMOD_SERIAL_OUT_EN
//   When defined, each decision is also shifted out MSB first on data_bit_out.
//   data_out_complete_bit marks the second (last) bit.
//
// Ports:
//   clk                   in   single clock, rising edge
//   rst                   in   synchronous active-high reset
//   sample_in   [7:0]     in   signed received sample
//   sample_valid          in   qualifies sample_in / sin_ref / cos_ref / sym_start
//   sin_ref     [7:0]     in   signed quadrature reference
//   cos_ref     [7:0]     in   signed in-phase reference
//   sym_start             in   qualified sample is first of a symbol
//   data_out    [1:0]     out  {I >= 0, Q >= 0} of the last symbol
//   data_valid            out  one-cycle strobe, data_out is new
//   i_soft      [ACC_W-1:0] out final signed I sum of the last symbol
//   q_soft      [ACC_W-1:0] out final signed Q sum of the last symbol
//   sync_err              out  one-cycle strobe, symbol aborted by early sym_start
//   state_dbg             out  FSM state (0 = IDLE, 1 = ACCUM)
//   data_bit_out          out  serial decision bit (serial build only)
//   data_out_complete_bit out  last serial bit strobe (serial build only)
//
// Handshake: a sample is consumed on any rising edge where sample_valid is
// high. There is no backpressure. data_valid and sync_err are single-cycle
// strobes with no acknowledge.
// -----------------------------------------------------------------------------
module qam_demodulator #(
    parameter int SAMPLES_PER_SYMBOL = 16,
    parameter int ACC_W              = 16 + $clog2(SAMPLES_PER_SYMBOL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic [7:0]       sin_ref,
    input  logic [7:0]       cos_ref,
    input  logic             sym_start,
    output logic [1:0]       data_out,
    output logic             data_valid,
    output logic [ACC_W-1:0] i_soft,
    output logic [ACC_W-1:0] q_soft,
    output logic             sync_err,
    output logic             state_dbg
`ifdef QAM_DEMOD_SERIAL_OUT_EN
    ,
    output logic             data_bit_out,
    output logic             data_out_complete_bit
`endif
);

    localparam int CNT_W = $clog2(SAMPLES_PER_SYMBOL + 1);
    // Count value held just before the final sample of a symbol arrives.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;

    logic signed [15:0]      prod_i;
    logic signed [15:0]      prod_q;
    logic signed [ACC_W-1:0] ext_i;
    logic signed [ACC_W-1:0] ext_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;

    always_comb begin
        prod_i = $signed(sample_in) * $signed(cos_ref);
        prod_q = $signed(sample_in) * $signed(sin_ref);
        ext_i  = {{(ACC_W-16){prod_i[15]}}, prod_i};
        ext_q  = {{(ACC_W-16){prod_q[15]}}, prod_q};
        // Accumulators are zero at count 0, so this is also the correct
        // first-sample value after a symbol boundary.
        sum_i  = acc_i + ext_i;
        sum_q  = acc_q + ext_q;
    end

    assign state_dbg = state;

`ifdef QAM_DEMOD_SERIAL_OUT_EN
    logic ser_pending;
    logic ser_lsb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            i_soft     <= '0;
            q_soft     <= '0;
            sync_err   <= 1'b0;
`ifdef QAM_DEMOD_SERIAL_OUT_EN
            data_bit_out          <= 1'b0;
            data_out_complete_bit <= 1'b0;
            ser_pending           <= 1'b0;
            ser_lsb               <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            sync_err   <= 1'b0;
`ifdef QAM_DEMOD_SERIAL_OUT_EN
            data_out_complete_bit <= 1'b0;
            // Second bit of the previous decision. It always completes before
            // the next decision because a symbol has at least 2 samples.
            if (ser_pending) begin
                data_bit_out          <= ser_lsb;
                data_out_complete_bit <= 1'b1;
                ser_pending           <= 1'b0;
            end
`endif
            if (sample_valid) begin
                case (state)
                    IDLE: begin
                        if (sym_start) begin
                            acc_i <= ext_i;
                            acc_q <= ext_q;
                            cnt   <= CNT_W'(1);
                            state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (sym_start && cnt != '0) begin
                            // Early resync: drop the partial symbol and restart
                            // with this sample as its first.
                            sync_err <= 1'b1;
                            acc_i    <= ext_i;
                            acc_q    <= ext_q;
                            cnt      <= CNT_W'(1);
                        end else if (cnt == LAST_CNT) begin
                            i_soft     <= sum_i;
                            q_soft     <= sum_q;
                            data_out   <= {~sum_i[ACC_W-1], ~sum_q[ACC_W-1]};
                            data_valid <= 1'b1;
                            acc_i      <= '0;
                            acc_q      <= '0;
                            cnt        <= '0;
`ifdef QAM_DEMOD_SERIAL_OUT_EN
                            data_bit_out <= ~sum_i[ACC_W-1];
                            ser_lsb      <= ~sum_q[ACC_W-1];
                            ser_pending  <= 1'b1;
`endif
                        end else begin
                            acc_i <= sum_i;
                            acc_q <= sum_q;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
